sseg_display_ctrl: RTL and testbench
====================================

// Module: sseg_display_ctrl
// PURPOSE
//  Display sequencer for the door-lock 4-digit 7-segment path. Arbitrates between keypad
//  digit entry and timed status messages (OPEN/ERR codes) and produces the registered
//  18-bit display word {mode[1:0], d3,d2,d1,d0} consumed by the sseg decoder.
//  mode 2'b01 = entry, 2'b10 = message, 2'b00 = idle dashes; digit 4'hF = blank segment.
// PARAMETERS
//  HOLD_CYCLES    50_000_000   message display time in clk cycles (>=2)
//  BLINK_CYCLES   12_500_000   half-period of message blink in clk cycles (>=1)
//  ENTRY_TIMEOUT  250_000_000  idle cycles after last key before entry is abandoned (>=2)
//  CNT_W          28           width of the internal timers; must hold all the above
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   reset, asynchronous, active-low
//  key_valid    in   1   one-cycle pulse: key_digit is valid
//  key_digit    in   4   BCD digit 0..9; values >9 are illegal
//  key_clear    in   1   one-cycle pulse: abandon the current entry
//  msg_valid    in   1   message request, held until accepted
//  msg_digits   in   16  message digits {d3,d2,d1,d0}
//  msg_blink    in   1   sampled with msg_valid; 1 = blink the message
//  msg_ready    out  1   1 when a message can be accepted (state != MSG)
//  disp_word    out  18  to sseg decoder: {mode, digits}
//  entry_code   out  16  current entry digits, newest in [3:0], blanks = 4'hF
//  entry_cnt    out  3   number of digits entered, 0..4
//  key_drop     out  1   one-cycle pulse: a key_valid was discarded
// BEHAVIOUR
//  Reset: state IDLE; disp_word = {2'b00,16'hFFFF}; entry_code = 16'hFFFF; entry_cnt = 0;
//   msg_ready = 1; key_drop = 0; all timers 0. Reset mid-operation aborts immediately.
//  All outputs are registered; an event accepted at edge N is visible on disp_word after edge N.
//  States: IDLE, ENTRY, MSG.
//  Accept msg: msg_valid && msg_ready. Highest priority in IDLE and ENTRY; latches msg_digits
//   and msg_blink, clears the entry (code FFFF, cnt 0), zeroes hold/blink timers, -> MSG.
//   A key_valid in the same cycle is dropped (key_drop = 1).
//  IDLE: legal key -> ENTRY, entry_code = {12'hFFF, key}, cnt = 1, entry timer = 0.
//   key_clear in IDLE: no effect.
//  ENTRY: legal key with cnt < 4 -> entry_code = {entry_code[11:0], key}, cnt + 1, timer = 0.
//   A key with cnt == 4 is dropped; the code is unchanged and the timer is not reset.
//   key_clear -> IDLE, entry cleared; a simultaneous key is dropped.
//   Timer == ENTRY_TIMEOUT-1 with no key -> IDLE, entry cleared.
//  MSG: msg_ready = 0; all keys are dropped; key_clear is ignored. The hold timer counts
//   0..HOLD_CYCLES-1. At HOLD_CYCLES-1 -> IDLE on the next edge (the message is shown for
//   exactly HOLD_CYCLES cycles). A waiting msg_valid is accepted in the following IDLE cycle.
//  Illegal key (>9) in any state: dropped with key_drop = 1; no state change.
//  disp_word: IDLE {00,FFFF}; ENTRY {01,entry_code}; MSG {10,msg} while blink phase is on,
//   {00,msg} while off. The phase starts on, toggles every BLINK_CYCLES, and stays on if
//   msg_blink = 0.
//  Timers saturate and never wrap; all comparisons are unsigned in CNT_W bits.
// TESTING (HOLD_CYCLES=20, BLINK_CYCLES=5, ENTRY_TIMEOUT=30)
//  1 reset, then keys 1,2,3,4 -> disp_word 18'h1_1234 as {01,1234}; cnt 4; a 5th key 7 ->
//    key_drop pulse, code stays 1234.
//  2 key 5 then 30 idle cycles -> {00,FFFF} exactly 30 cycles after the key edge; cnt 0.
//  3 entry 9,8 with msg_valid + key 3 in the same cycle, msg 16'h0E0F, blink 0 -> key_drop,
//    {10,0E0F} for 20 cycles, then {00,FFFF}; msg_ready low throughout.
//  4 msg with blink 1 -> mode sequence 10x5, 00x5, 10x5, 00x5, then idle; keys are dropped in MSG.
//  5 key_clear + key 4 in the same cycle during ENTRY -> IDLE, key_drop; key 10 in IDLE -> drop,
//    stays IDLE.
//  6 assert reset_n low mid-MSG -> all outputs take reset values asynchronously; msg_ready = 1.

Source files
------------

// File: rtl/sseg_display_ctrl.sv
// Display sequencer for the door-lock 4-digit 7-segment path: arbitrates keypad entry
// against timed status messages and produces the registered {mode, digits} display word.
module sseg_display_ctrl #(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int BLINK_CYCLES  = 12_500_000,
  parameter int ENTRY_TIMEOUT = 250_000_000,
  parameter int CNT_W         = 28
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_key_valid,
  input  logic [3:0]  i_key_digit,
  input  logic        i_key_clear,
  input  logic        i_msg_valid,
  input  logic [15:0] i_msg_digits,
  input  logic        i_msg_blink,
  output logic        o_msg_ready,
  output logic [17:0] o_disp_word,
  output logic [15:0] o_entry_code,
  output logic [2:0]  o_entry_cnt,
  output logic        o_key_drop
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    MSG   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENTRY_LAST = CNT_W'(ENTRY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t            r_state;
  logic [15:0]       r_entry_code;
  logic [2:0]        r_entry_cnt;
  logic [CNT_W-1:0]  r_entry_tmr;
  logic [15:0]       r_msg_digits;
  logic              r_msg_blink;
  logic [CNT_W-1:0]  r_hold_cnt;
  logic [CNT_W-1:0]  r_blink_cnt;
  logic              r_blink_on;
  logic              r_msg_ready;
  logic              r_key_drop;
  logic [17:0]       r_disp_word;

  state_t            w_next_state;
  logic [15:0]       w_next_code;
  logic [2:0]        w_next_cnt;
  logic [CNT_W-1:0]  w_next_tmr;
  logic [15:0]       w_next_msg;
  logic              w_next_blink_en;
  logic [CNT_W-1:0]  w_next_hold;
  logic [CNT_W-1:0]  w_next_bcnt;
  logic              w_next_phase;
  logic              w_next_drop;
  logic [17:0]       w_next_disp;
  logic              w_key_legal;
  logic              w_msg_accept;

  // Next-state logic; a message accept overrides whatever IDLE/ENTRY decided for the key.
  always_comb begin
    w_next_state    = r_state;
    w_next_code     = r_entry_code;
    w_next_cnt      = r_entry_cnt;
    w_next_tmr      = r_entry_tmr;
    w_next_msg      = r_msg_digits;
    w_next_blink_en = r_msg_blink;
    w_next_hold     = r_hold_cnt;
    w_next_bcnt     = r_blink_cnt;
    w_next_phase    = r_blink_on;
    w_key_legal     = i_key_valid && (i_key_digit <= 4'd9);
    w_msg_accept    = i_msg_valid && r_msg_ready;
    w_next_drop     = i_key_valid && !w_key_legal;

    case (r_state)
      IDLE: begin
        if (w_key_legal) begin
          w_next_state = ENTRY;
          w_next_code  = {12'hFFF, i_key_digit};
          w_next_cnt   = 3'd1;
          w_next_tmr   = '0;
        end
      end

      ENTRY: begin
        if (i_key_clear) begin
          w_next_state = IDLE;
          w_next_code  = 16'hFFFF;
          w_next_cnt   = 3'd0;
          w_next_tmr   = '0;
          w_next_drop  = i_key_valid;
        end else if (w_key_legal && (r_entry_cnt < 3'd4)) begin
          w_next_code = {r_entry_code[11:0], i_key_digit};
          w_next_cnt  = r_entry_cnt + 3'd1;
          w_next_tmr  = '0;
        end else begin
          // A full entry drops further keys without restarting the inactivity timer.
          if (w_key_legal) begin
            w_next_drop = 1'b1;
          end
          if (r_entry_tmr >= ENTRY_LAST) begin
            w_next_state = IDLE;
            w_next_code  = 16'hFFFF;
            w_next_cnt   = 3'd0;
            w_next_tmr   = '0;
          end else if (r_entry_tmr != CNT_MAX) begin
            w_next_tmr = r_entry_tmr + CNT_ONE;
          end
        end
      end

      MSG: begin
        w_next_drop = i_key_valid;
        if (r_hold_cnt >= HOLD_LAST) begin
          w_next_state = IDLE;
        end else if (r_hold_cnt != CNT_MAX) begin
          w_next_hold = r_hold_cnt + CNT_ONE;
        end
        if (r_msg_blink) begin
          if (r_blink_cnt >= BLINK_LAST) begin
            w_next_bcnt  = '0;
            w_next_phase = !r_blink_on;
          end else if (r_blink_cnt != CNT_MAX) begin
            w_next_bcnt = r_blink_cnt + CNT_ONE;
          end
        end
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase

    if (w_msg_accept) begin
      w_next_state    = MSG;
      w_next_code     = 16'hFFFF;
      w_next_cnt      = 3'd0;
      w_next_tmr      = '0;
      w_next_msg      = i_msg_digits;
      w_next_blink_en = i_msg_blink;
      w_next_hold     = '0;
      w_next_bcnt     = '0;
      w_next_phase    = 1'b1;
      w_next_drop     = i_key_valid;
    end

    case (w_next_state)
      ENTRY:   w_next_disp = {2'b01, w_next_code};
      MSG:     w_next_disp = {(w_next_phase ? 2'b10 : 2'b00), w_next_msg};
      default: w_next_disp = {2'b00, 16'hFFFF};
    endcase
  end

  // Display word and status flags are registered from next-state values so they
  // reflect an event in the cycle right after the edge that accepted it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_entry_code <= 16'hFFFF;
      r_entry_cnt  <= 3'd0;
      r_entry_tmr  <= '0;
      r_msg_digits <= 16'hFFFF;
      r_msg_blink  <= 1'b0;
      r_hold_cnt   <= '0;
      r_blink_cnt  <= '0;
      r_blink_on   <= 1'b1;
      r_msg_ready  <= 1'b1;
      r_key_drop   <= 1'b0;
      r_disp_word  <= {2'b00, 16'hFFFF};
    end else begin
      r_state      <= w_next_state;
      r_entry_code <= w_next_code;
      r_entry_cnt  <= w_next_cnt;
      r_entry_tmr  <= w_next_tmr;
      r_msg_digits <= w_next_msg;
      r_msg_blink  <= w_next_blink_en;
      r_hold_cnt   <= w_next_hold;
      r_blink_cnt  <= w_next_bcnt;
      r_blink_on   <= w_next_phase;
      r_msg_ready  <= (w_next_state != MSG);
      r_key_drop   <= w_next_drop;
      r_disp_word  <= w_next_disp;
    end
  end

  assign o_msg_ready  = r_msg_ready;
  assign o_disp_word  = r_disp_word;
  assign o_entry_code = r_entry_code;
  assign o_entry_cnt  = r_entry_cnt;
  assign o_key_drop   = r_key_drop;

endmodule

// File: tb/tb_sseg_display_ctrl.sv
// Directed self-checking bench for sseg_display_ctrl with short timer parameters.
module tb_sseg_display_ctrl;

  logic        clk;
  logic        reset_n;
  logic        i_key_valid;
  logic [3:0]  i_key_digit;
  logic        i_key_clear;
  logic        i_msg_valid;
  logic [15:0] i_msg_digits;
  logic        i_msg_blink;
  logic        o_msg_ready;
  logic [17:0] o_disp_word;
  logic [15:0] o_entry_code;
  logic [2:0]  o_entry_cnt;
  logic        o_key_drop;

  int errors = 0;
  int checks = 0;

  sseg_display_ctrl #(
    .HOLD_CYCLES  (20),
    .BLINK_CYCLES (5),
    .ENTRY_TIMEOUT(30),
    .CNT_W        (28)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_key_valid (i_key_valid),
    .i_key_digit (i_key_digit),
    .i_key_clear (i_key_clear),
    .i_msg_valid (i_msg_valid),
    .i_msg_digits(i_msg_digits),
    .i_msg_blink (i_msg_blink),
    .o_msg_ready (o_msg_ready),
    .o_disp_word (o_disp_word),
    .o_entry_code(o_entry_code),
    .o_entry_cnt (o_entry_cnt),
    .o_key_drop  (o_key_drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // One clock step, leaving time 1ns past the edge so outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_key(input logic [3:0] d);
    i_key_valid = 1'b1;
    i_key_digit = d;
    step();
    i_key_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    i_key_valid = 1'b0; i_key_digit = 4'd0; i_key_clear = 1'b0;
    i_msg_valid = 1'b0; i_msg_digits = 16'h0000; i_msg_blink = 1'b0;
    #12;
    checks++; if (o_disp_word !== 18'h0FFFF) begin errors++; $display("[TB] FAIL reset_disp got=%h exp=%h", o_disp_word, 18'h0FFFF); end
    checks++; if (o_entry_code !== 16'hFFFF) begin errors++; $display("[TB] FAIL reset_code got=%h exp=FFFF", o_entry_code); end
    checks++; if (o_entry_cnt !== 3'd0) begin errors++; $display("[TB] FAIL reset_cnt got=%0d exp=0", o_entry_cnt); end
    checks++; if (o_msg_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", o_msg_ready); end
    checks++; if (o_key_drop !== 1'b0) begin errors++; $display("[TB] FAIL reset_drop got=%b exp=0", o_key_drop); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_entry();
    press_key(4'd1);
    checks++; if (o_disp_word !== 18'h1FFF1) begin errors++; $display("[TB] FAIL entry_first got=%h exp=%h", o_disp_word, 18'h1FFF1); end
    press_key(4'd2);
    press_key(4'd3);
    press_key(4'd4);
    checks++; if (o_disp_word !== 18'h11234) begin errors++; $display("[TB] FAIL entry_disp got=%h exp=%h", o_disp_word, 18'h11234); end
    checks++; if (o_entry_cnt !== 3'd4) begin errors++; $display("[TB] FAIL entry_cnt got=%0d exp=4", o_entry_cnt); end
    checks++; if (o_key_drop !== 1'b0) begin errors++; $display("[TB] FAIL entry_nodrop got=%b exp=0", o_key_drop); end
    press_key(4'd7);
    checks++; if (o_key_drop !== 1'b1) begin errors++; $display("[TB] FAIL fifth_drop got=%b exp=1", o_key_drop); end
    checks++; if (o_entry_code !== 16'h1234) begin errors++; $display("[TB] FAIL fifth_code got=%h exp=1234", o_entry_code); end
    step();
    checks++; if (o_key_drop !== 1'b0) begin errors++; $display("[TB] FAIL drop_pulse got=%b exp=0", o_key_drop); end
    i_key_clear = 1'b1;
    step();
    i_key_clear = 1'b0;
    checks++; if (o_disp_word !== 18'h0FFFF) begin errors++; $display("[TB] FAIL clear_idle got=%h exp=%h", o_disp_word, 18'h0FFFF); end
  endtask

  task automatic test_timeout();
    press_key(4'd5);
    checks++; if (o_disp_word !== 18'h1FFF5) begin errors++; $display("[TB] FAIL timeout_start got=%h exp=%h", o_disp_word, 18'h1FFF5); end
    for (int i = 1; i < 30; i++) begin
      step();
      checks++; if (o_disp_word !== 18'h1FFF5) begin errors++; $display("[TB] FAIL timeout_hold[%0d] got=%h exp=%h", i, o_disp_word, 18'h1FFF5); end
    end
    step();
    checks++; if (o_disp_word !== 18'h0FFFF) begin errors++; $display("[TB] FAIL timeout_idle got=%h exp=%h", o_disp_word, 18'h0FFFF); end
    checks++; if (o_entry_cnt !== 3'd0) begin errors++; $display("[TB] FAIL timeout_cnt got=%0d exp=0", o_entry_cnt); end
  endtask

  task automatic test_back_to_back();
    press_key(4'd9);
    press_key(4'd8);
    i_msg_valid = 1'b1; i_msg_digits = 16'h0E0F; i_msg_blink = 1'b0;
    i_key_valid = 1'b1; i_key_digit = 4'd3;
    step();
    i_msg_valid = 1'b0; i_key_valid = 1'b0;
    checks++; if (o_key_drop !== 1'b1) begin errors++; $display("[TB] FAIL msg_keydrop got=%b exp=1", o_key_drop); end
    checks++; if (o_entry_cnt !== 3'd0) begin errors++; $display("[TB] FAIL msg_cnt got=%0d exp=0", o_entry_cnt); end
    for (int i = 0; i < 20; i++) begin
      checks++; if (o_disp_word !== 18'h20E0F) begin errors++; $display("[TB] FAIL msg_disp[%0d] got=%h exp=%h", i, o_disp_word, 18'h20E0F); end
      checks++; if (o_msg_ready !== 1'b0) begin errors++; $display("[TB] FAIL msg_ready[%0d] got=%b exp=0", i, o_msg_ready); end
      step();
    end
    checks++; if (o_disp_word !== 18'h0FFFF) begin errors++; $display("[TB] FAIL msg_end got=%h exp=%h", o_disp_word, 18'h0FFFF); end
    checks++; if (o_msg_ready !== 1'b1) begin errors++; $display("[TB] FAIL msg_end_ready got=%b exp=1", o_msg_ready); end
  endtask

  task automatic test_blink();
    logic [17:0] exp;
    i_msg_valid = 1'b1; i_msg_digits = 16'hAB12; i_msg_blink = 1'b1;
    step();
    i_msg_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      exp = {(((i / 5) % 2) == 0) ? 2'b10 : 2'b00, 16'hAB12};
      checks++; if (o_disp_word !== exp) begin errors++; $display("[TB] FAIL blink[%0d] got=%h exp=%h", i, o_disp_word, exp); end
      if (i == 8) begin
        checks++; if (o_key_drop !== 1'b1) begin errors++; $display("[TB] FAIL blink_keydrop got=%b exp=1", o_key_drop); end
        checks++; if (o_entry_cnt !== 3'd0) begin errors++; $display("[TB] FAIL blink_cnt got=%0d exp=0", o_entry_cnt); end
      end
      i_key_valid = (i == 7);
      i_key_digit = 4'd6;
      step();
    end
    checks++; if (o_disp_word !== 18'h0FFFF) begin errors++; $display("[TB] FAIL blink_end got=%h exp=%h", o_disp_word, 18'h0FFFF); end
  endtask

  task automatic test_clear();
    press_key(4'd2);
    checks++; if (o_disp_word !== 18'h1FFF2) begin errors++; $display("[TB] FAIL clear_pre got=%h exp=%h", o_disp_word, 18'h1FFF2); end
    i_key_clear = 1'b1; i_key_valid = 1'b1; i_key_digit = 4'd4;
    step();
    i_key_clear = 1'b0; i_key_valid = 1'b0;
    checks++; if (o_disp_word !== 18'h0FFFF) begin errors++; $display("[TB] FAIL clear_disp got=%h exp=%h", o_disp_word, 18'h0FFFF); end
    checks++; if (o_key_drop !== 1'b1) begin errors++; $display("[TB] FAIL clear_drop got=%b exp=1", o_key_drop); end
    press_key(4'hA);
    checks++; if (o_key_drop !== 1'b1) begin errors++; $display("[TB] FAIL illegal_drop got=%b exp=1", o_key_drop); end
    checks++; if (o_disp_word !== 18'h0FFFF) begin errors++; $display("[TB] FAIL illegal_idle got=%h exp=%h", o_disp_word, 18'h0FFFF); end
    checks++; if (o_entry_cnt !== 3'd0) begin errors++; $display("[TB] FAIL illegal_cnt got=%0d exp=0", o_entry_cnt); end
  endtask

  task automatic test_reset_mid_msg();
    i_msg_valid = 1'b1; i_msg_digits = 16'h5678; i_msg_blink = 1'b0;
    step();
    i_msg_valid = 1'b0;
    step();
    step();
    checks++; if (o_disp_word !== 18'h25678) begin errors++; $display("[TB] FAIL midmsg_disp got=%h exp=%h", o_disp_word, 18'h25678); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (o_disp_word !== 18'h0FFFF) begin errors++; $display("[TB] FAIL async_disp got=%h exp=%h", o_disp_word, 18'h0FFFF); end
    checks++; if (o_msg_ready !== 1'b1) begin errors++; $display("[TB] FAIL async_ready got=%b exp=1", o_msg_ready); end
    checks++; if (o_entry_code !== 16'hFFFF) begin errors++; $display("[TB] FAIL async_code got=%h exp=FFFF", o_entry_code); end
    checks++; if (o_entry_cnt !== 3'd0) begin errors++; $display("[TB] FAIL async_cnt got=%0d exp=0", o_entry_cnt); end
    checks++; if (o_key_drop !== 1'b0) begin errors++; $display("[TB] FAIL async_drop got=%b exp=0", o_key_drop); end
    #3;
    reset_n = 1'b1;
    step();
    checks++; if (o_disp_word !== 18'h0FFFF) begin errors++; $display("[TB] FAIL post_reset got=%h exp=%h", o_disp_word, 18'h0FFFF); end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_timeout();
    test_back_to_back();
    test_blink();
    test_clear();
    test_reset_mid_msg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
